// File: rtl/fifo_line_reader_pkg.sv
// Shared definitions for fifo_line_reader.
//   - default widths for the pixel, line length, frame height, blanking and
//     underrun counter fields
//   - FSM state encoding
//   - bit positions of the frame flags carried alongside each pixel
package fifo_line_reader_pkg;

  localparam int DW_DEF    = 16;
  localparam int LW_DEF    = 12;
  localparam int FW_DEF    = 11;
  localparam int BW_DEF    = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  // Flag vector layout: {EOF, EOL, SOF}
  localparam int FLAG_SOF  = 0;
  localparam int FLAG_EOL  = 1;
  localparam int FLAG_EOF  = 2;
  localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/fifo_line_reader_out_stage.sv
// flr_out_stage: single-entry registered output slot holding one pixel and
// its frame flags. A load overwrites the slot and marks it valid; without a
// load the slot empties once downstream accepts it. Contents are frozen while
// the slot is valid and downstream is stalled.
// Ports:
//   rd_clk, rd_rst   clock, asynchronous active-high reset
//   load             write load_data/load_flags into the slot
//   load_data        pixel to store
//   load_flags       frame flags to store with the pixel
//   out_rdy          downstream ready
//   out_data         stored pixel
//   out_flags        stored flags
//   out_vld          slot holds a pixel
//   slot_free        slot can take a new pixel this cycle
module flr_out_stage
  import fifo_line_reader_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NF = NUM_FLAGS
) (
  input  logic          rd_clk,
  input  logic          rd_rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [NF-1:0] load_flags,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic [NF-1:0] out_flags,
  output logic          out_vld,
  output logic          slot_free
);

  logic [DW-1:0] data_reg;
  logic [NF-1:0] flags_reg;
  logic          vld_reg;

  // The slot may be refilled in the same cycle the current pixel is taken.
  assign slot_free = ~vld_reg | out_rdy;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      data_reg  <= '0;
      flags_reg <= '0;
      vld_reg   <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      flags_reg <= load_flags;
      vld_reg   <= 1'b1;
    end else if (out_rdy) begin
      vld_reg   <= 1'b0;
    end
  end

  assign out_data  = data_reg;
  assign out_flags = flags_reg;
  assign out_vld   = vld_reg;

endmodule

// File: rtl/fifo_line_reader.sv
// fifo_line_reader: read-side consumer of the pixel prefetch FIFO. Pops
// pixels via the FIFO rd_vld/rd_en handshake, frames them into lines and
// frames (SOF/EOL/EOF), inserts horizontal blanking between lines, honours
// downstream backpressure and flags mid-line FIFO starvation.
// Optional feature macro: FIFO_LINE_READER_UCNT_EN adds a saturating
// underrun counter and its output port underrun_cnt.
// Ports:
//   rd_clk, rd_rst     FIFO read clock, asynchronous active-high reset
//   enable             start a frame (looked at only while idle)
//   line_len           pixels per line, latched at frame start
//   frame_lines        lines per frame, latched at frame start
//   hblank_len         idle cycles between lines, latched at frame start
//   fifo_data/vld      FIFO read data and valid
//   fifo_en            FIFO pop request
//   out_data/vld/rdy   registered pixel stream to the filter
//   out_sof/eol/eof    frame flags, qualified by out_vld
//   busy               a frame is in progress
//   underrun           one-cycle pulse when a line starves mid-way
//   underrun_cnt       saturating underrun count (macro only)
module fifo_line_reader
  import fifo_line_reader_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF,
  parameter int FW = FW_DEF,
  parameter int BW = BW_DEF
`ifdef FIFO_LINE_READER_UCNT_EN
  ,
  parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             enable,
  input  logic [LW-1:0]    line_len,
  input  logic [FW-1:0]    frame_lines,
  input  logic [BW-1:0]    hblank_len,
  input  logic [DW-1:0]    fifo_data,
  input  logic             fifo_vld,
  output logic             fifo_en,
  output logic [DW-1:0]    out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic             underrun
`ifdef FIFO_LINE_READER_UCNT_EN
  ,
  output logic [CNT_W-1:0] underrun_cnt
`endif
);

  localparam logic [LW-1:0] PIX_ONE  = LW'(1);
  localparam logic [FW-1:0] LINE_ONE = FW'(1);
  localparam logic [BW-1:0] HB_ONE   = BW'(1);

  state_t        state_reg, state_next;
  logic [LW-1:0] line_len_reg, line_len_next;
  logic [FW-1:0] frame_lines_reg, frame_lines_next;
  logic [BW-1:0] hblank_reg, hblank_next;
  logic [LW-1:0] pix_cnt_reg, pix_cnt_next;
  logic [FW-1:0] line_cnt_reg, line_cnt_next;
  logic [BW-1:0] hb_cnt_reg, hb_cnt_next;
  logic          armed_reg, armed_next;

  logic                 slot_free;
  logic                 pop;
  logic                 at_eol;
  logic                 last_line;
  logic                 starve;
  logic [NUM_FLAGS-1:0] flags_in;
  logic [NUM_FLAGS-1:0] flags_out;

  assign at_eol    = (pix_cnt_reg == (line_len_reg - PIX_ONE));
  assign last_line = (line_cnt_reg == (frame_lines_reg - LINE_ONE));

  assign fifo_en = (state_reg == ACTIVE) & fifo_vld & slot_free;
  assign pop     = fifo_vld & fifo_en;
  assign busy    = (state_reg != IDLE);

  // Starvation only counts once a line has begun: waiting for the first
  // pixel of a line is normal inter-line slack, not an underrun.
  assign starve   = (state_reg == ACTIVE) && (pix_cnt_reg != '0) &&
                    (pix_cnt_reg < line_len_reg) && slot_free && !fifo_vld;
  assign underrun = starve & armed_reg;

  // Flags describe the pixel being popped this cycle.
  assign flags_in[FLAG_SOF] = (pix_cnt_reg == '0) && (line_cnt_reg == '0);
  assign flags_in[FLAG_EOL] = at_eol;
  assign flags_in[FLAG_EOF] = at_eol && last_line;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_reg       <= IDLE;
      line_len_reg    <= '0;
      frame_lines_reg <= '0;
      hblank_reg      <= '0;
      pix_cnt_reg     <= '0;
      line_cnt_reg    <= '0;
      hb_cnt_reg      <= '0;
      armed_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      line_len_reg    <= line_len_next;
      frame_lines_reg <= frame_lines_next;
      hblank_reg      <= hblank_next;
      pix_cnt_reg     <= pix_cnt_next;
      line_cnt_reg    <= line_cnt_next;
      hb_cnt_reg      <= hb_cnt_next;
      armed_reg       <= armed_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    line_len_next    = line_len_reg;
    frame_lines_next = frame_lines_reg;
    hblank_next      = hblank_reg;
    pix_cnt_next     = pix_cnt_reg;
    line_cnt_next    = line_cnt_reg;
    hb_cnt_next      = hb_cnt_reg;
    armed_next       = armed_reg;

    unique case (state_reg)
      IDLE: begin
        if (enable && (line_len != '0) && (frame_lines != '0)) begin
          state_next       = ACTIVE;
          line_len_next    = line_len;
          frame_lines_next = frame_lines;
          hblank_next      = hblank_len;
          pix_cnt_next     = '0;
          line_cnt_next    = '0;
          hb_cnt_next      = '0;
          armed_next       = 1'b1;
        end
      end

      ACTIVE: begin
        if (pop) begin
          armed_next   = 1'b1;
          pix_cnt_next = pix_cnt_reg + PIX_ONE;
          if (at_eol) begin
            pix_cnt_next = '0;
            if (last_line) begin
              state_next = VBLANK;
            end else if (hblank_reg == '0) begin
              // Back-to-back lines: the next line starts on the next cycle.
              line_cnt_next = line_cnt_reg + LINE_ONE;
            end else begin
              state_next  = HBLANK;
              hb_cnt_next = '0;
            end
          end
        end else if (starve) begin
          // One pulse per starvation episode; the next pop re-arms it.
          armed_next = 1'b0;
        end
      end

      HBLANK: begin
        hb_cnt_next = hb_cnt_reg + HB_ONE;
        if (hb_cnt_reg == (hblank_reg - HB_ONE)) begin
          state_next    = ACTIVE;
          hb_cnt_next   = '0;
          pix_cnt_next  = '0;
          line_cnt_next = line_cnt_reg + LINE_ONE;
        end
      end

      VBLANK: begin
        // Hold the frame open until the last pixel has left the slot.
        if (!out_vld) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  flr_out_stage #(
    .DW (DW),
    .NF (NUM_FLAGS)
  ) u_out_stage (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .load       (pop),
    .load_data  (fifo_data),
    .load_flags (flags_in),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_flags  (flags_out),
    .out_vld    (out_vld),
    .slot_free  (slot_free)
  );

  assign out_sof = flags_out[FLAG_SOF];
  assign out_eol = flags_out[FLAG_EOL];
  assign out_eof = flags_out[FLAG_EOF];

`ifdef FIFO_LINE_READER_UCNT_EN
  logic [CNT_W-1:0] ucnt_reg;
  localparam logic [CNT_W-1:0] UCNT_ONE = CNT_W'(1);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      ucnt_reg <= '0;
    end else if (underrun && (ucnt_reg != '1)) begin
      ucnt_reg <= ucnt_reg + UCNT_ONE;
    end
  end

  assign underrun_cnt = ucnt_reg;
`endif

endmodule
